id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 98 +++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. It captures decoded operands, register indices and control
// from the ID stage. It can hold its contents (stall) or be overwritten with an ADD x0 bubble (flush).
module id_ex_reg #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            valid_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rd1_in,
   input  logic [XLEN-1:0] rd2_in,
   input  logic [XLEN-1:0] imm_in,
   input  logic [4:0]      rs1_in,
   input  logic [4:0]      rs2_in,
   input  logic [4:0]      rd_in,
   input  logic [3:0]      funct_in,
   input  logic [1:0]      alu_op_in,
   input  logic [5:0]      ctrl_in,
   output logic            valid_out,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] rd1_out,
   output logic [XLEN-1:0] rd2_out,
   output logic [XLEN-1:0] imm_out,
   output logic [4:0]      rs1_out,
   output logic [4:0]      rs2_out,
   output logic [4:0]      rd_out,
   output logic [3:0]      funct_out,
   output logic [1:0]      alu_op_out,
   output logic [5:0]      ctrl_out
);

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_rd1;
   logic [XLEN-1:0] r_rd2;
   logic [XLEN-1:0] r_imm;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [4:0]      r_rd;
   logic [3:0]      r_funct;
   logic [1:0]      r_alu_op;
   logic [5:0]      r_ctrl;

   logic            w_clear;
   logic            w_load;
   logic [5:0]      w_ctrl_gated;
   logic [1:0]      w_alu_op_gated;

   // Reset and flush both produce the all-zero bubble; flush beats stall.
   assign w_clear        = reset | flush;
   assign w_load         = ~stall;
   // An invalid slot must never carry side-effecting control into EX.
   assign w_ctrl_gated   = valid_in ? ctrl_in   : 6'b0;
   assign w_alu_op_gated = valid_in ? alu_op_in : 2'b0;

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_rd1    <= '0;
         r_rd2    <= '0;
         r_imm    <= '0;
         r_rs1    <= 5'd0;
         r_rs2    <= 5'd0;
         r_rd     <= 5'd0;
         r_funct  <= 4'd0;
         r_alu_op <= 2'd0;
         r_ctrl   <= 6'd0;
      end else if (w_load) begin
         r_valid  <= valid_in;
         r_pc     <= pc_in;
         r_rd1    <= rd1_in;
         r_rd2    <= rd2_in;
         r_imm    <= imm_in;
         r_rs1    <= rs1_in;
         r_rs2    <= rs2_in;
         r_rd     <= rd_in;
         r_funct  <= funct_in;
         r_alu_op <= w_alu_op_gated;
         r_ctrl   <= w_ctrl_gated;
      end
   end

   assign valid_out  = r_valid;
   assign pc_out     = r_pc;
   assign rd1_out    = r_rd1;
   assign rd2_out    = r_rd2;
   assign imm_out    = r_imm;
   assign rs1_out    = r_rs1;
   assign rs2_out    = r_rs2;
   assign rd_out     = r_rd;
   assign funct_out  = r_funct;
   assign alu_op_out = r_alu_op;
   assign ctrl_out   = r_ctrl;

endmodule
